conbus_arb_rr_wd: RTL and testbench

//  Round-robin bus arbiter with a transaction watchdog for the shared-bus conbus interconnect.

---
 rtl/conbus_arb_rr_wd_if.sv | 15 +
 rtl/conbus_arb_rr_wd.sv | 106 ++++++++++
 tb/tb_conbus_arb_rr_wd.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/conbus_arb_rr_wd_if.sv
// Shared-bus arbitration handshake between the conbus requesters and the arbiter.
// The arbiter takes the slave side; the bus fabric/requesters take the master side.
interface conbus_arb_rr_wd_if #(
   parameter int N_MASTERS = 5
);
   logic [N_MASTERS-1:0] req;
   logic                 bus_stb;
   logic                 bus_ack;
   logic [2:0]           gnt;
   logic                 gnt_valid;
   logic                 bus_err;

   modport slave  (input  req, bus_stb, bus_ack, output gnt, gnt_valid, bus_err);
   modport master (output req, bus_stb, bus_ack, input  gnt, gnt_valid, bus_err);
endinterface

// File: rtl/conbus_arb_rr_wd.sv
// Round-robin conbus arbiter: tenure held while CYC stays up, with a strobe watchdog
// that forces a one-cycle error termination and keeps timeout statistics.
module conbus_arb_rr_wd #(
   parameter int N_MASTERS = 5,
   parameter int TIMEOUT   = 1024,
   parameter int TO_CNT_W  = 8
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   conbus_arb_rr_wd_if.slave    bus,
   input  logic                 to_clr,
   output logic [2:0]           to_master,
   output logic [TO_CNT_W-1:0]  to_count
);
   localparam int WD_W = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, OWN, ERR} state_t;

   state_t              state_q, state_d;
   logic [2:0]          gnt_q, gnt_d;
   logic                gnt_valid_q, gnt_valid_d;
   logic                bus_err_q, bus_err_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [2:0]          to_master_q, to_master_d;
   logic [TO_CNT_W-1:0] to_count_q, to_count_d;
   logic [2:0]          pick, idx;
   logic                found;

   // Search starts one past the owner so the owner itself is considered last.
   always_comb begin
      pick  = gnt_q;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N_MASTERS; k++) begin
         idx = 3'((int'(gnt_q) + k) % N_MASTERS);
         if (!found && bus.req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      wd_d        = '0;
      to_master_d = to_master_q;
      to_count_d  = to_count_q;
      unique case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d = OWN;
               gnt_d   = pick;
            end
         end
         OWN: begin
            if (bus.bus_stb && !bus.bus_ack) begin
               if (wd_q == WD_MAX) state_d = ERR;
               else                wd_d    = wd_q + 1'b1;
            end
            // A pending timeout wins; the CYC drop is picked up after the ERR cycle.
            if (state_d != ERR && !bus.req[gnt_q]) begin
               if (|bus.req) gnt_d   = pick;
               else          state_d = IDLE;
               wd_d = '0;
            end
         end
         ERR: begin
            state_d     = OWN;
            to_master_d = gnt_q;
            to_count_d  = (&to_count_q) ? to_count_q : to_count_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (to_clr) to_count_d = (state_q == ERR) ? TO_CNT_W'(1) : '0;
      gnt_valid_d = (state_d != IDLE);
      bus_err_d   = (state_d == ERR);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= 3'(N_MASTERS - 1);
         gnt_valid_q <= 1'b0;
         bus_err_q   <= 1'b0;
         wd_q        <= '0;
         to_master_q <= '0;
         to_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         bus_err_q   <= bus_err_d;
         wd_q        <= wd_d;
         to_master_q <= to_master_d;
         to_count_q  <= to_count_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.bus_err   = bus_err_q;
   assign to_master     = to_master_q;
   assign to_count      = to_count_q;
endmodule

// File: tb/tb_conbus_arb_rr_wd.sv
// Bench for conbus_arb_rr_wd: vector table for arbitration order plus hand-written
// watchdog, saturation, clear and async-reset sequences.
module tb_conbus_arb_rr_wd;
   localparam int N  = 5;
   localparam int TO = 16;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          to_clr = 1'b0;
   logic [2:0]    to_master;
   logic [CW-1:0] to_count;
   int            tests = 0;
   int            fails = 0;

   conbus_arb_rr_wd_if #(.N_MASTERS(N)) bus ();

   conbus_arb_rr_wd #(.N_MASTERS(N), .TIMEOUT(TO), .TO_CNT_W(CW)) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus),
      .to_clr    (to_clr),
      .to_master (to_master),
      .to_count  (to_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [4:0] req;
      logic [2:0] gnt;
      logic       vld;
      logic       err;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   function automatic vec_t mk(logic rst, logic [4:0] req, logic [2:0] gnt, logic vld);
      vec_t v;
      v.rst = rst; v.req = req; v.gnt = gnt; v.vld = vld; v.err = 1'b0;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      rst_n = 1'b0;
      bus.req = '0; bus.bus_stb = 1'b0; bus.bus_ack = 1'b0; to_clr = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   // Steps until bus_err is seen (or budget expires); returns edge count, -1 on timeout.
   task automatic wait_err(input int budget, output int edges);
      edges = -1;
      for (int k = 1; k <= budget; k++) begin
         step();
         if (bus.bus_err) begin
            edges = k;
            break;
         end
      end
   endtask

   initial begin
      int   first, nerr, e;
      vec_t v;
      bus.req = '0; bus.bus_stb = 1'b0; bus.bus_ack = 1'b0;

      // Arbitration order: two-requester handover, then full rotation with 3-cycle tenures.
      tbl.push_back(mk(1, 5'b00110, 3'd1, 1));
      tbl.push_back(mk(0, 5'b00100, 3'd2, 1));
      tbl.push_back(mk(0, 5'b00100, 3'd2, 1));
      tbl.push_back(mk(0, 5'b00000, 3'd2, 0));
      tbl.push_back(mk(0, 5'b00000, 3'd2, 0));
      tbl.push_back(mk(1, 5'b11111, 3'd0, 1));
      tbl.push_back(mk(0, 5'b11111, 3'd0, 1));
      tbl.push_back(mk(0, 5'b11111, 3'd0, 1));
      tbl.push_back(mk(0, 5'b11110, 3'd1, 1));
      tbl.push_back(mk(0, 5'b11111, 3'd1, 1));
      tbl.push_back(mk(0, 5'b11111, 3'd1, 1));
      tbl.push_back(mk(0, 5'b11101, 3'd2, 1));
      tbl.push_back(mk(0, 5'b11111, 3'd2, 1));
      tbl.push_back(mk(0, 5'b11111, 3'd2, 1));
      tbl.push_back(mk(0, 5'b11011, 3'd3, 1));
      tbl.push_back(mk(0, 5'b11111, 3'd3, 1));
      tbl.push_back(mk(0, 5'b11111, 3'd3, 1));
      tbl.push_back(mk(0, 5'b10111, 3'd4, 1));
      tbl.push_back(mk(0, 5'b11111, 3'd4, 1));
      tbl.push_back(mk(0, 5'b11111, 3'd4, 1));
      tbl.push_back(mk(0, 5'b01111, 3'd0, 1));
      tbl.push_back(mk(0, 5'b00000, 3'd0, 0));

      foreach (tbl[i]) begin
         if (tbl[i].rst) begin
            rst_pulse();
            chk("reset gnt", bus.gnt, N - 1);
            chk("reset gnt_valid", bus.gnt_valid, 0);
            chk("reset bus_err", bus.bus_err, 0);
            chk("reset to_count", to_count, 0);
         end
         bus.req = tbl[i].req;
         exp_q.push_back(tbl[i]);
         step();
         v = exp_q.pop_front();
         chk($sformatf("vec%0d gnt", i), bus.gnt, v.gnt);
         chk($sformatf("vec%0d gnt_valid", i), bus.gnt_valid, v.vld);
         chk($sformatf("vec%0d bus_err", i), bus.bus_err, v.err);
      end

      // Watchdog: unacked strobe on master 2 errors 16 cycles after first strobe cycle.
      rst_pulse();
      bus.req = 5'b00100;
      step();
      chk("wd grant", bus.gnt, 2);
      bus.bus_stb = 1'b1;
      first = -1; nerr = 0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (bus.bus_err) begin
            nerr++;
            if (first < 0) begin
               first = k;
               chk("err gnt", bus.gnt, 2);
               chk("err gnt_valid", bus.gnt_valid, 1);
            end
            bus.bus_stb = 1'b0;
         end
      end
      chk("err latency", first, TO);
      chk("err pulse width", nerr, 1);
      chk("to_master", to_master, 2);
      chk("to_count first", to_count, 1);

      // ACK in the threshold cycle suppresses the error and restarts the count.
      bus.bus_stb = 1'b1;
      nerr = 0;
      for (int k = 0; k < TO - 1; k++) begin
         step();
         if (bus.bus_err) nerr++;
      end
      bus.bus_ack = 1'b1;
      step();
      if (bus.bus_err) nerr++;
      bus.bus_ack = 1'b0;
      chk("ack threshold no err", nerr, 0);
      chk("ack threshold to_count", to_count, 1);
      wait_err(40, e);
      chk("restart latency", e, TO);
      bus.bus_stb = 1'b0;
      step();
      chk("to_count second", to_count, 2);

      // Saturation after 300 more timeouts, then clear coinciding with an ERR cycle.
      bus.bus_stb = 1'b1;
      nerr = 0;
      for (int k = 0; k < 300 * (TO + 1) + 100 && nerr < 300; k++) begin
         step();
         if (bus.bus_err) nerr++;
      end
      chk("300 timeouts seen", nerr, 300);
      step();
      chk("to_count saturated", to_count, 255);
      wait_err(40, e);
      chk("err before clr", e > 0 ? 1 : 0, 1);
      to_clr = 1'b1;
      step();
      to_clr = 1'b0;
      chk("clr with err", to_count, 1);
      chk("to_master kept", to_master, 2);
      bus.bus_stb = 1'b0;
      to_clr = 1'b1;
      step();
      to_clr = 1'b0;
      chk("plain clr", to_count, 0);

      // Async reset during an error pulse, then rearbitration from master 0.
      bus.req = 5'b01000;
      step();
      chk("handover gnt", bus.gnt, 3);
      bus.bus_stb = 1'b1;
      wait_err(40, e);
      chk("err before reset", bus.bus_err, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async gnt", bus.gnt, N - 1);
      chk("async gnt_valid", bus.gnt_valid, 0);
      chk("async bus_err", bus.bus_err, 0);
      chk("async to_master", to_master, 0);
      chk("async to_count", to_count, 0);
      bus.bus_stb = 1'b0;
      bus.req = 5'b11111;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      chk("post reset gnt", bus.gnt, 0);
      chk("post reset gnt_valid", bus.gnt_valid, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
